adc_sample_packer: RTL

//   Captures Sub-ADC conversion words on adc_ack and buffers them in a small FIFO.

---
 rtl/giraffe_pkg.sv | 21 ++
 rtl/packer_fifo.sv | 53 +++++
 rtl/adc_sample_packer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/giraffe_pkg.sv
// Shared definitions for the Giraffe ADC sample packer: TX state encoding,
// default frame header byte and the data-byte framing rule.
package giraffe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_WAIT_LO,
        ST_WAIT_HI
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hC0;

    // Bit 7 of a data or checksum byte is always 0 so it can never alias the header.
    function automatic logic [7:0] data_byte(input logic [6:0] payload);
        return {1'b0, payload};
    endfunction

endpackage

// File: rtl/packer_fifo.sv
// Sample FIFO for adc_sample_packer: binary pointers with a wrap bit,
// combinational head read, synchronous clear.
module packer_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         wr_en, rd_en;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q + {{AW{1'b0}}, wr_en};
        rptr_d = rptr_q + {{AW{1'b0}}, rd_en};
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/adc_sample_packer.sv
// ADC conversion-word capture and UART framer in the clk_adc domain.
// Define PACKER_CHECKSUM_EN to append a mod-128 checksum byte to every frame.
module adc_sample_packer
    import giraffe_pkg::*;
#(
    parameter int         NUM_bit       = 6,
    parameter int         UART_NUM_DATA = 8,
    parameter int         FIFO_DEPTH    = 16,
    parameter int         FRAME_LEN     = 256,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     cap_ena,
    input  logic                     adc_ack,
    input  logic [NUM_bit-1:0]       adc_dout,
    output logic                     uart_wreq,
    output logic [UART_NUM_DATA-1:0] uart_wdata,
    input  logic                     uart_rdy,
    output logic                     overflow,
    output logic                     frame_done,
    output logic [17:0]              cnt_frames
);
    logic [2:0]               ack_sync_q, ack_sync_d;
    logic                     cap_ena_q;
    logic                     restart, ack_rise, push, pop;
    logic                     fifo_full, fifo_empty;
    logic [UART_NUM_DATA-1:0] push_byte, fifo_rdata;

    tx_state_e                state_q, state_d, last_q, last_d;
    logic                     wreq_q, wreq_d, frame_done_q, frame_done_d;
    logic                     overflow_q, overflow_d;
    logic [UART_NUM_DATA-1:0] wdata_q, wdata_d;
    logic [15:0]              sample_cnt_q, sample_cnt_d;
    logic [17:0]              cnt_frames_q, cnt_frames_d;
`ifdef PACKER_CHECKSUM_EN
    logic [6:0]               sum_q, sum_d;
`endif

    // Stages 0/1 synchronize the async strobe; stage 2 is the edge-detect history.
    assign ack_sync_d = {ack_sync_q[1:0], adc_ack};
    assign ack_rise   = ack_sync_q[1] & ~ack_sync_q[2];
    assign restart    = cap_ena & ~cap_ena_q;
    assign push       = ack_rise & cap_ena & ~restart;
    assign push_byte  = UART_NUM_DATA'(data_byte(7'(adc_dout)));
    assign overflow_d = restart ? 1'b0 : (overflow_q | (push & fifo_full));

    packer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_NUM_DATA)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .clr   (restart),
        .push  (push),
        .pop   (pop),
        .wdata (push_byte),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        wreq_d       = 1'b0;
        wdata_d      = wdata_q;
        frame_done_d = 1'b0;
        sample_cnt_d = sample_cnt_q;
        cnt_frames_d = cnt_frames_q;
        pop          = 1'b0;
`ifdef PACKER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        if (restart) begin
            state_d      = ST_IDLE;
            sample_cnt_d = '0;
            cnt_frames_d = '0;
`ifdef PACKER_CHECKSUM_EN
            sum_d        = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (!fifo_empty) state_d = ST_HDR;
                ST_HDR: if (uart_rdy) begin
                    wreq_d  = 1'b1;
                    wdata_d = UART_NUM_DATA'(SYNC_BYTE);
                    last_d  = ST_HDR;
                    state_d = ST_WAIT_LO;
`ifdef PACKER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
                ST_DATA: if (uart_rdy && !fifo_empty) begin
                    pop          = 1'b1;
                    wreq_d       = 1'b1;
                    wdata_d      = fifo_rdata;
                    sample_cnt_d = sample_cnt_q + 16'd1;
                    last_d       = ST_DATA;
                    state_d      = ST_WAIT_LO;
`ifdef PACKER_CHECKSUM_EN
                    sum_d        = sum_q + fifo_rdata[6:0];
`endif
                end
`ifdef PACKER_CHECKSUM_EN
                ST_CSUM: if (uart_rdy) begin
                    wreq_d  = 1'b1;
                    wdata_d = UART_NUM_DATA'(data_byte(sum_q));
                    last_d  = ST_CSUM;
                    state_d = ST_WAIT_LO;
                end
`endif
                ST_WAIT_LO: if (!uart_rdy) state_d = ST_WAIT_HI;
                ST_WAIT_HI: if (uart_rdy) begin
                    if (last_q == ST_HDR ||
                        (last_q == ST_DATA && sample_cnt_q != 16'(FRAME_LEN)))
                        state_d = ST_DATA;
`ifdef PACKER_CHECKSUM_EN
                    else if (last_q == ST_DATA)
                        state_d = ST_CSUM;
`endif
                    else begin
                        frame_done_d = 1'b1;
                        cnt_frames_d = cnt_frames_q + 18'd1;
                        sample_cnt_d = '0;
                        state_d      = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ack_sync_q   <= '0;
            cap_ena_q    <= 1'b0;
            state_q      <= ST_IDLE;
            last_q       <= ST_IDLE;
            wreq_q       <= 1'b0;
            wdata_q      <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            sample_cnt_q <= '0;
            cnt_frames_q <= '0;
`ifdef PACKER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            ack_sync_q   <= ack_sync_d;
            cap_ena_q    <= cap_ena;
            state_q      <= state_d;
            last_q       <= last_d;
            wreq_q       <= wreq_d;
            wdata_q      <= wdata_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            sample_cnt_q <= sample_cnt_d;
            cnt_frames_q <= cnt_frames_d;
`ifdef PACKER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign uart_wreq  = wreq_q;
    assign uart_wdata = wdata_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;
    assign cnt_frames = cnt_frames_q;

endmodule
